// File: rtl/hash_ctrl_pkg.sv
// Shared types and default timing constants for the hash cycle controller.
// No logic; imported by hash_cycle_ctrl and tick_gen.
package hash_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_LATCH = 2'd3
    } hash_state_e;

    localparam int DEF_TICKS_PER_SAMPLE   = 2000;
    localparam int DEF_SAMPLES_PER_PERIOD = 2500;
    localparam int DEF_HASH_TIMEOUT       = 64;

    // Bits needed for a counter running 0..n-1 (never below one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler and period counter producing the sample and period strobes.
// Latency: strobes are combinational from the counter registers; free-running.
// No backpressure: the cadence never stalls and does not depend on any consumer.
module tick_gen
    import hash_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SAMPLE   = DEF_TICKS_PER_SAMPLE,
    parameter int SAMPLES_PER_PERIOD = DEF_SAMPLES_PER_PERIOD
) (
    input  logic sysclk,
    input  logic rst,
    output logic sample_stb,
    output logic period_stb
);

    localparam int PW = cnt_width(TICKS_PER_SAMPLE);
    localparam int SW = cnt_width(SAMPLES_PER_PERIOD);

    logic [PW-1:0] presc;
    logic [SW-1:0] per_cnt;

    assign sample_stb = (presc == PW'(TICKS_PER_SAMPLE - 1));
    assign period_stb = sample_stb && (per_cnt == SW'(SAMPLES_PER_PERIOD - 1));

    always_ff @(posedge sysclk) begin
        if (rst) begin
            presc   <= '0;
            per_cnt <= '0;
        end else begin
            if (sample_stb)
                presc <= '0;
            else
                presc <= presc + 1'b1;

            if (period_stb)
                per_cnt <= '0;
            else if (sample_stb)
                per_cnt <= per_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hash_cycle_ctrl.sv
// Periodic hash request sequencer with button-toggled display enable (HASH_TIMEOUT_EN adds a WAIT timeout).
// Latency: time_tick on the period strobe, hash_start next cycle, disp_value one cycle after hash_done.
// No backpressure: a period strobe arriving while busy is dropped and flagged in the sticky overrun bit.
module hash_cycle_ctrl
    import hash_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SAMPLE   = DEF_TICKS_PER_SAMPLE,
    parameter int SAMPLES_PER_PERIOD = DEF_SAMPLES_PER_PERIOD,
    parameter int HASH_TIMEOUT       = DEF_HASH_TIMEOUT
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        button_in,
    input  logic        hash_done,
    input  logic [15:0] hash_value,
    output logic        time_tick,
    output logic        hash_start,
    output logic [15:0] disp_value,
    output logic        disp_enable,
    output logic        busy,
    output logic        hash_err,
    output logic        overrun
);

    logic sample_stb;
    logic period_stb;

    tick_gen #(
        .TICKS_PER_SAMPLE  (TICKS_PER_SAMPLE),
        .SAMPLES_PER_PERIOD(SAMPLES_PER_PERIOD)
    ) u_tick_gen (
        .sysclk    (sysclk),
        .rst       (rst),
        .sample_stb(sample_stb),
        .period_stb(period_stb)
    );

    // Button: two-flop synchronizer, then accept a new level only when two
    // consecutive sample-strobe samples agree.
    logic btn_meta;
    logic btn_sync;
    logic btn_samp;
    logic btn_deb;
    logic btn_deb_d;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            btn_samp    <= 1'b0;
            btn_deb     <= 1'b0;
            btn_deb_d   <= 1'b0;
            disp_enable <= 1'b0;
        end else begin
            btn_meta  <= button_in;
            btn_sync  <= btn_meta;
            btn_deb_d <= btn_deb;
            if (sample_stb) begin
                btn_samp <= btn_sync;
                if (btn_sync == btn_samp)
                    btn_deb <= btn_sync;
            end
            if (btn_deb && !btn_deb_d)
                disp_enable <= ~disp_enable;
        end
    end

    hash_state_e state;
    hash_state_e state_nxt;
    logic        tmo_hit;

`ifdef HASH_TIMEOUT_EN
    localparam int TW = cnt_width(HASH_TIMEOUT);

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == ST_WAIT) && !hash_done && (tmo_cnt == TW'(HASH_TIMEOUT - 1));

    // Counter is held at zero outside WAIT so it starts fresh on every WAIT entry.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            tmo_cnt  <= '0;
            hash_err <= 1'b0;
        end else begin
            if (state != ST_WAIT)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit)
                hash_err <= 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;

    assign tmo_hit        = 1'b0;
    assign hash_err       = 1'b0;
    assign unused_tmo_cfg = (HASH_TIMEOUT != 0);
`endif

    always_comb begin
        state_nxt = state;
        time_tick = 1'b0;
        case (state)
            ST_IDLE: begin
                if (period_stb) begin
                    state_nxt = ST_REQ;
                    time_tick = 1'b1;
                end
            end
            ST_REQ:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (hash_done)
                    state_nxt = ST_LATCH;
                else if (tmo_hit)
                    state_nxt = ST_IDLE;
            end
            ST_LATCH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign hash_start = (state == ST_REQ);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            disp_value <= '0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_WAIT) && hash_done)
                disp_value <= hash_value;
            if (period_stb && (state != ST_IDLE))
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hash_cycle_ctrl.sv
// Scoreboard bench for hash_cycle_ctrl with a short period (4 x 5 cycles) and timeout of 8.
module tb_hash_cycle_ctrl;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        button_in = 1'b0;
    logic        hash_done = 1'b0;
    logic [15:0] hash_value = 16'h0;
    logic        time_tick;
    logic        hash_start;
    logic [15:0] disp_value;
    logic        disp_enable;
    logic        busy;
    logic        hash_err;
    logic        overrun;

    hash_cycle_ctrl #(
        .TICKS_PER_SAMPLE  (4),
        .SAMPLES_PER_PERIOD(5),
        .HASH_TIMEOUT      (8)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .button_in  (button_in),
        .hash_done  (hash_done),
        .hash_value (hash_value),
        .time_tick  (time_tick),
        .hash_start (hash_start),
        .disp_value (disp_value),
        .disp_enable(disp_enable),
        .busy       (busy),
        .hash_err   (hash_err),
        .overrun    (overrun)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } disp_exp_t;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_tick_q[$];
    int          exp_start_q[$];
    disp_exp_t   exp_disp_q[$];
    logic        exp_en_q[$];
    disp_exp_t   mon_e;
    logic [15:0] disp_prev = 16'h0;
    logic        en_prev = 1'b0;
    logic [21:0] outs;

    assign outs = {time_tick, hash_start, busy, hash_err, overrun, disp_enable, disp_value};

    // Cycle 1 is the first cycle with rst low.
    always @(posedge sysclk) cyc <= rst ? 1 : cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge sysclk) begin
        if (!rst) begin
            if (time_tick) begin
                if (exp_tick_q.size() == 0) check_val("tick_extra", cyc, 0);
                else check_val("tick_cycle", cyc, exp_tick_q.pop_front());
            end
            if (hash_start) begin
                if (exp_start_q.size() == 0) check_val("start_extra", cyc, 0);
                else check_val("start_cycle", cyc, exp_start_q.pop_front());
            end
            if (disp_value != disp_prev) begin
                if (exp_disp_q.size() == 0) check_val("disp_extra", disp_value, disp_prev);
                else begin
                    mon_e = exp_disp_q.pop_front();
                    check_val("disp_cycle", cyc, mon_e.cyc);
                    check_val("disp_val", disp_value, mon_e.val);
                end
            end
            if (disp_enable != en_prev) begin
                if (exp_en_q.size() == 0) check_val("en_extra", disp_enable, en_prev);
                else check_val("en_toggle", disp_enable, exp_en_q.pop_front());
            end
        end
        disp_prev <= disp_value;
        en_prev   <= disp_enable;
    end

    task automatic goto(input int k);
        int n = 0;
        while (cyc < k && n < 1000) begin
            @(posedge sysclk); #1;
            n++;
        end
        if (cyc < k) check_val("goto_bound", cyc, k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hash_done = 1'b0;
        hash_value = 16'h0;
        button_in = 1'b0;
        @(posedge sysclk); #1;
        @(posedge sysclk); #1;
        @(negedge sysclk);
        check_val("rst_outs", outs, 0);
        @(posedge sysclk); #1;
        rst = 1'b0;
    endtask

    // Hasher model: answer the next hash_start dly cycles later.
    task automatic serve(input int dly, input logic [15:0] v);
        int n = 0;
        while (!hash_start && n < 200) begin
            @(posedge sysclk); #1;
            n++;
        end
        if (!hash_start) check_val("start_wait", n, 0);
        else begin
            goto(cyc + dly);
            hash_done = 1'b1;
            hash_value = v;
            exp_disp_q.push_back('{cyc + 1, v});
            @(posedge sysclk); #1;
            hash_done = 1'b0;
            hash_value = 16'h0;
        end
    endtask

    task automatic end_session();
        check_val("tick_left", exp_tick_q.size(), 0);
        check_val("start_left", exp_start_q.size(), 0);
        check_val("disp_left", exp_disp_q.size(), 0);
        check_val("en_left", exp_en_q.size(), 0);
    endtask

    initial begin
        // Basic cycle: tick 20, start 21, done 24, display 25, idle 26.
        do_reset();
        exp_tick_q.push_back(20);
        exp_start_q.push_back(21);
        serve(3, 16'hBEEF);
        goto(25);
        @(negedge sysclk);
        check_val("latch_busy", busy, 1);
        check_val("latch_disp", disp_value, 16'hBEEF);
        goto(26);
        @(negedge sysclk);
        check_val("idle_busy", busy, 0);
        check_val("s1_overrun", overrun, 0);
        end_session();

        // Withheld hash_done.
        do_reset();
        exp_tick_q.push_back(20);
        exp_start_q.push_back(21);
`ifdef HASH_TIMEOUT_EN
        exp_tick_q.push_back(40);
        exp_start_q.push_back(41);
        goto(29);
        @(negedge sysclk);
        check_val("tmo_busy_pre", busy, 1);
        check_val("tmo_err_pre", hash_err, 0);
        goto(30);
        @(negedge sysclk);
        check_val("tmo_busy", busy, 0);
        check_val("tmo_err", hash_err, 1);
        check_val("tmo_disp", disp_value, 0);
        goto(51);
        @(negedge sysclk);
        check_val("tmo_err_sticky", hash_err, 1);
        check_val("tmo_busy2", busy, 0);
        check_val("tmo_overrun", overrun, 0);
`else
        goto(40);
        @(negedge sysclk);
        check_val("no_tick40", time_tick, 0);
        check_val("overrun_pre", overrun, 0);
        goto(41);
        @(negedge sysclk);
        check_val("overrun_set", overrun, 1);
        check_val("wait_busy", busy, 1);
        check_val("no_err", hash_err, 0);
        goto(59);
        @(negedge sysclk);
        check_val("wait_busy59", busy, 1);
        // Period strobe and hash_done together in WAIT.
        goto(60);
        hash_done = 1'b1;
        hash_value = 16'h1234;
        exp_disp_q.push_back('{61, 16'h1234});
        goto(61);
        hash_done = 1'b0;
        hash_value = 16'h0;
        goto(62);
        @(negedge sysclk);
        check_val("coll_busy", busy, 0);
        check_val("coll_overrun", overrun, 1);
`endif
        end_session();

        // Reset during WAIT, then a stray hash_done.
        do_reset();
        exp_tick_q.push_back(20);
        exp_start_q.push_back(21);
        goto(23);
        check_val("pre_rst_busy", busy, 1);
        end_session();
        do_reset();
        goto(3);
        hash_done = 1'b1;
        hash_value = 16'hDEAD;
        goto(4);
        hash_done = 1'b0;
        hash_value = 16'h0;
        @(negedge sysclk);
        check_val("stray_ignored", outs, 0);
        exp_tick_q.push_back(20);
        exp_start_q.push_back(21);
        serve(3, 16'h5A5A);
        goto(26);
        end_session();

        // Button bounce, hold, release, press again.
        do_reset();
        fork
            begin
                goto(2);
                exp_en_q.push_back(1'b1);
                for (int i = 0; i < 6; i++) begin
                    button_in = (i % 2 == 0);
                    @(posedge sysclk); #1;
                end
                button_in = 1'b1;
                goto(48);
                @(negedge sysclk);
                check_val("en_after_press", disp_enable, 1);
                button_in = 1'b0;
                goto(72);
                @(negedge sysclk);
                check_val("en_after_release", disp_enable, 1);
                exp_en_q.push_back(1'b0);
                button_in = 1'b1;
                goto(96);
                @(negedge sysclk);
                check_val("en_after_press2", disp_enable, 0);
            end
            begin
                for (int k = 1; k <= 4; k++) begin
                    exp_tick_q.push_back(20 * k);
                    exp_start_q.push_back(20 * k + 1);
                    serve(3, 16'h1000 + 16'(k));
                end
            end
        join
        goto(98);
        end_session();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_cycle_ctrl.md
HASH_CYCLE_CTRL -- requirements
Module: hash_cycle_ctrl

Interface
REQ-001 Parameter TICKS_PER_SAMPLE, default 2000, sets the sysclk cycles per button-sample strobe (1 MHz to 500 Hz).
REQ-002 Parameter SAMPLES_PER_PERIOD, default 2500, sets the sample strobes per hash period (5 s).
REQ-003 Parameter HASH_TIMEOUT, default 64, sets the maximum sysclk cycles spent waiting for hash_done.
REQ-004 sysclk  in  1  single system clock, 1 MHz; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 button_in  in  1  raw push button, asynchronous, bouncy.
REQ-007 hash_done  in  1  hasher completion pulse.
REQ-008 hash_value  in  16  hasher result, valid while hash_done=1.
REQ-009 time_tick  out  1  one-cycle pulse advancing the timekeeper.
REQ-010 hash_start  out  1  one-cycle hasher request pulse.
REQ-011 disp_value  out  16  latched hash for the BCD display.
REQ-012 disp_enable  out  1  display enable, toggled by the button.
REQ-013 busy  out  1  high whenever the FSM is not IDLE.
REQ-014 hash_err  out  1  sticky hash-timeout flag.
REQ-015 overrun  out  1  sticky dropped-period flag.

Function
REQ-016 The prescaler SHALL count 0..TICKS_PER_SAMPLE-1 and raise an internal sample strobe on the terminal count.
REQ-017 The period counter SHALL advance on each sample strobe and raise an internal period strobe on the strobe where it equals SAMPLES_PER_PERIOD-1, then wrap to 0.
REQ-018 button_in SHALL pass a 2-flop synchronizer; the debounced level SHALL update only when two consecutive sample-strobe samples agree.
REQ-019 A 0-to-1 transition of the debounced level SHALL toggle disp_enable on the following cycle; holding the button SHALL cause no further toggles.
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT and LATCH.
REQ-021 IDLE + period strobe -> REQ, with time_tick=1 in the REQ-entry cycle.
REQ-022 In REQ, hash_start=1 for exactly one cycle, then -> WAIT.
REQ-023 In WAIT, hash_done=1 -> LATCH; the block captures hash_value and disp_value shows it on the next cycle; LATCH -> IDLE after one cycle.
REQ-024 hash_done SHALL be ignored outside WAIT.
REQ-025 A period strobe outside IDLE SHALL be dropped: no time_tick, overrun set to 1.
REQ-026 On a period strobe and hash_done in the same WAIT cycle, the block SHALL take the done path and drop the strobe per REQ-025.
REQ-027 The first time_tick SHALL occur in cycle TICKS_PER_SAMPLE*SAMPLES_PER_PERIOD after rst deasserts (cycle 1 is the first cycle with rst=0), then every TICKS_PER_SAMPLE*SAMPLES_PER_PERIOD cycles.
REQ-028 Counters SHALL wrap and never saturate; the period cadence SHALL not depend on FSM state.

Reset
REQ-029 rst=1 SHALL clear, on the next edge, the prescaler, period counter, synchronizer, debounced level, FSM (IDLE), timeout counter and all outputs (disp_value=0, disp_enable=0, pulses 0, busy=0, hash_err=0, overrun=0).
REQ-030 rst asserted mid-WAIT SHALL abandon the request; a later hash_done SHALL be ignored.
REQ-031 hash_err and overrun SHALL clear only on rst.

Configuration
REQ-032 With HASH_TIMEOUT_EN defined, the block SHALL start a WAIT cycle counter on WAIT entry; HASH_TIMEOUT cycles without hash_done -> IDLE, hash_err=1, disp_value unchanged.
REQ-033 Without HASH_TIMEOUT_EN, WAIT SHALL persist until hash_done and hash_err SHALL be constant 0.

Structure
REQ-034 Package hash_ctrl_pkg SHALL hold the FSM state enum and the default TICKS_PER_SAMPLE, SAMPLES_PER_PERIOD and HASH_TIMEOUT constants.
REQ-035 Sub-module tick_gen SHALL implement the prescaler and period counter (REQ-016, REQ-017) and output the sample and period strobes.

Verification (TICKS_PER_SAMPLE=4, SAMPLES_PER_PERIOD=5, HASH_TIMEOUT=8)
REQ-036 Release rst, hash_done returned 3 cycles after hash_start with hash_value=16'hBEEF -> time_tick in cycle 20, hash_start in 21, disp_value=16'hBEEF from 25, busy=0 from 26.
REQ-037 button_in bouncing 1/0 each cycle for 6 cycles, then 1 held for 40 cycles -> exactly one disp_enable toggle 0->1; release then press again -> 1->0.
REQ-038 hash_done withheld for 30 cycles -> second period strobe dropped, overrun=1, no second time_tick in cycle 40.
REQ-039 With HASH_TIMEOUT_EN, no hash_done -> hash_err=1 eight cycles after WAIT entry, FSM IDLE, disp_value unchanged; without it, busy stays 1.
REQ-040 rst pulsed during WAIT, then a stray hash_done -> all outputs at reset values, disp_value=0, next time_tick in cycle 20 after release.
